// File: rtl/bsg_manycore_host_pkg.sv
// rtl/bsg_manycore_host_pkg.sv - shared states and EPA constants for the host loader
package bsg_manycore_host_pkg;

  // Loader sequence: stream program, wait for responses, unfreeze, watch, stop.
  typedef enum logic [2:0] {
    e_load,
    e_drain,
    e_unfreeze,
    e_run,
    e_done
  } host_loader_state_e;

  // Packet opcode for a remote store.
  localparam logic [1:0] e_op_store = 2'b01;

  // EPAs the loader writes to or watches for.
  localparam logic [27:0] FREEZE_CSR_EPA = 28'h0000100;
  localparam logic [27:0] FINISH_EPA     = 28'h000EAD0;
  localparam logic [27:0] FAIL_EPA       = 28'h000EAD8;

endpackage

// File: rtl/bsg_manycore_host_loader_if.sv
// rtl/bsg_manycore_host_loader_if.sv - load, packet, request and status bundle of the host loader
interface bsg_manycore_host_loader_if #(
  parameter int addr_width_p      = 28,
  parameter int data_width_p      = 32,
  parameter int x_cord_width_p    = 2,
  parameter int y_cord_width_p    = 3,
  parameter int max_out_credits_p = 16
) ();

  localparam int packet_width_lp = 2 + data_width_p/8 + addr_width_p + data_width_p
                                   + 2*(x_cord_width_p + y_cord_width_p);
  localparam int credit_width_lp = $clog2(max_out_credits_p+1);

  logic                       load_v_i;
  logic [addr_width_p-1:0]    load_addr_i;
  logic [data_width_p-1:0]    load_data_i;
  logic [x_cord_width_p-1:0]  load_x_i;
  logic [y_cord_width_p-1:0]  load_y_i;
  logic                       load_last_i;
  logic                       load_yumi_o;
  logic                       pkt_v_o;
  logic [packet_width_lp-1:0] pkt_o;
  logic                       pkt_ready_i;
  logic                       credit_return_i;
  logic                       req_v_i;
  logic [addr_width_p-1:0]    req_addr_i;
  logic [data_width_p-1:0]    req_data_i;
  logic                       req_yumi_o;
  logic                       done_o;
  logic                       fail_o;
  logic [credit_width_lp-1:0] out_credits_o;

  modport master (
    input  load_v_i, load_addr_i, load_data_i, load_x_i, load_y_i, load_last_i,
    input  pkt_ready_i, credit_return_i, req_v_i, req_addr_i, req_data_i,
    output load_yumi_o, pkt_v_o, pkt_o, req_yumi_o, done_o, fail_o, out_credits_o
  );

  modport slave (
    output load_v_i, load_addr_i, load_data_i, load_x_i, load_y_i, load_last_i,
    output pkt_ready_i, credit_return_i, req_v_i, req_addr_i, req_data_i,
    input  load_yumi_o, pkt_v_o, pkt_o, req_yumi_o, done_o, fail_o, out_credits_o
  );

endinterface

// File: rtl/bsg_manycore_credit_counter.sv
// rtl/bsg_manycore_credit_counter.sv - saturating up/down counter of available store credits
module bsg_manycore_credit_counter #(
  parameter int max_p   = 16,
  parameter int width_p = $clog2(max_p+1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o
);

  localparam logic [width_p-1:0] full_lp = width_p'(max_p);

  // Starts full; a send and a return in the same cycle cancel out; both ends saturate.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_o <= full_lp;
    end else if (up_i && !down_i && count_o != full_lp) begin
      count_o <= count_o + 1'b1;
    end else if (down_i && !up_i && count_o != '0) begin
      count_o <= count_o - 1'b1;
    end
  end

  // A return with every credit already home means the endpoint returned more than was sent.
  assert property (@(posedge clk_i) disable iff (reset_i)
                   !(up_i && !down_i && count_o == full_lp));

endmodule

// File: rtl/bsg_manycore_host_loader.sv
// rtl/bsg_manycore_host_loader.sv - host sequencer: program load, tile unfreeze, finish/fail watch
module bsg_manycore_host_loader
  import bsg_manycore_host_pkg::*;
#(
  parameter int addr_width_p      = 28,
  parameter int data_width_p      = 32,
  parameter int x_cord_width_p    = 2,
  parameter int y_cord_width_p    = 3,
  parameter int num_tiles_x_p     = 4,
  parameter int num_tiles_y_p     = 4,
  parameter int max_out_credits_p = 16
) (
  input logic clk_i,
  input logic reset_i,
  bsg_manycore_host_loader_if.master io
);

  localparam int credit_width_lp = $clog2(max_out_credits_p+1);
  localparam logic [credit_width_lp-1:0] credits_full_lp = credit_width_lp'(max_out_credits_p);
  localparam logic [x_cord_width_p-1:0]  x_last_lp = x_cord_width_p'(num_tiles_x_p-1);
  localparam logic [y_cord_width_p-1:0]  y_last_lp = y_cord_width_p'(num_tiles_y_p-1);

  host_loader_state_e state_r, state_n;

  logic [credit_width_lp-1:0] credits;
  logic [x_cord_width_p-1:0]  x_r, dst_x;
  logic [y_cord_width_p-1:0]  y_r, dst_y;
  logic [addr_width_p-1:0]    pkt_addr;
  logic [data_width_p-1:0]    pkt_data;
  logic                       pkt_v, load_yumi, send;
  logic                       done_r, fail_r;
  logic                       is_finish, is_fail;
  logic                       unused_req_data;

  assign unused_req_data = ^io.req_data_i;
  assign is_finish = io.req_addr_i == addr_width_p'(FINISH_EPA);
  assign is_fail   = io.req_addr_i == addr_width_p'(FAIL_EPA);
  assign send      = pkt_v && io.pkt_ready_i;

  bsg_manycore_credit_counter #(
    .max_p   (max_out_credits_p),
    .width_p (credit_width_lp)
  ) credit_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .up_i    (io.credit_return_i),
    .down_i  (send),
    .count_o (credits)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_load;
    else         state_r <= state_n;
  end

  // Next state and packet contents; load words pass straight through, unfreeze stores come from the sweep counters.
  always_comb begin
    state_n   = state_r;
    pkt_v     = 1'b0;
    load_yumi = 1'b0;
    pkt_addr  = io.load_addr_i;
    pkt_data  = io.load_data_i;
    dst_x     = io.load_x_i;
    dst_y     = io.load_y_i;
    case (state_r)
      e_load: begin
        pkt_v     = io.load_v_i && (credits != '0);
        load_yumi = pkt_v && io.pkt_ready_i;
        if (load_yumi && io.load_last_i) state_n = e_drain;
      end
      e_drain: begin
        if (credits == credits_full_lp) state_n = e_unfreeze;
      end
      e_unfreeze: begin
        pkt_v    = credits != '0;
        pkt_addr = addr_width_p'(FREEZE_CSR_EPA);
        pkt_data = '0;
        dst_x    = x_r;
        dst_y    = y_r;
        if (pkt_v && io.pkt_ready_i && x_r == x_last_lp && y_r == y_last_lp) state_n = e_run;
      end
      e_run: begin
        if (io.req_v_i && (is_finish || is_fail)) state_n = e_done;
      end
      default: begin
        state_n = state_r;
      end
    endcase
    // Reset kills any packet in flight immediately.
    if (reset_i) begin
      pkt_v     = 1'b0;
      load_yumi = 1'b0;
    end
  end

  // Unfreeze sweep: x runs fastest, compute rows start at y=1; advances only on an accepted store.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_r <= '0;
      y_r <= y_cord_width_p'(1);
    end else if (state_r == e_unfreeze && send) begin
      if (x_r == x_last_lp) begin
        x_r <= '0;
        y_r <= y_r + 1'b1;
      end else begin
        x_r <= x_r + 1'b1;
      end
    end
  end

  // Sticky completion flags, only armed once the program is running.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      done_r <= 1'b0;
      fail_r <= 1'b0;
    end else if (state_r == e_run && io.req_v_i) begin
      if (is_finish) begin
        done_r <= 1'b1;
      end else if (is_fail) begin
        done_r <= 1'b1;
        fail_r <= 1'b1;
      end
    end
  end

  assign io.pkt_v_o       = pkt_v;
  assign io.load_yumi_o   = load_yumi;
  assign io.pkt_o         = {e_op_store, {(data_width_p/8){1'b1}}, pkt_addr, pkt_data,
                             dst_x, dst_y, {x_cord_width_p{1'b0}}, {y_cord_width_p{1'b0}}};
  assign io.req_yumi_o    = io.req_v_i;
  assign io.done_o        = done_r;
  assign io.fail_o        = fail_r;
  assign io.out_credits_o = credits;

endmodule

// File: tb/tb_bsg_manycore_host_loader.sv
// tb/tb_bsg_manycore_host_loader.sv - scoreboard bench for the host loader
module tb_bsg_manycore_host_loader;
  import bsg_manycore_host_pkg::*;

  localparam int MAXC = 16;

  typedef struct {
    logic [75:0] pkt;
    bit          unf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   stall_until = 0;
  int   pending = 0;
  bit   loading = 0;
  bit   ret_always = 1;
  bit   ready_always = 1;
  bit   prev_stall = 0;
  bit   seen_unf = 0;
  bit   accept, ret;
  logic [75:0] prev_pkt;
  exp_t exp_q[$];
  exp_t e;

  bsg_manycore_host_loader_if #(.max_out_credits_p(MAXC)) hb ();
  bsg_manycore_host_loader_if #(.max_out_credits_p(2))    h2 ();

  bsg_manycore_host_loader #(.max_out_credits_p(MAXC)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .io      (hb)
  );

  bsg_manycore_host_loader #(.max_out_credits_p(2)) dut2 (
    .clk_i   (clk),
    .reset_i (rst2),
    .io      (h2)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle count used to time the forced ready stall.
  always @(posedge clk) cyc <= cyc + 1;

  // Endpoint ready: forced low during a stall window, otherwise always-on or random.
  always @(posedge clk) begin
    #1;
    if (cyc < stall_until) hb.pkt_ready_i = 1'b0;
    else if (ready_always) hb.pkt_ready_i = 1'b1;
    else hb.pkt_ready_i = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [75:0] mk(input logic [27:0] a, input logic [31:0] d,
                                     input logic [1:0] x, input logic [2:0] y);
    return {e_op_store, 4'hF, a, d, x, y, 2'b00, 3'b000};
  endfunction

  // Monitor: pops the scoreboard on every accepted packet, checks flow rules, models the responding endpoint.
  always @(negedge clk) begin
    if (rst) begin
      pending = 0;
      hb.credit_return_i = 1'b0;
      prev_stall = 0;
      seen_unf = 0;
    end else begin
      accept = hb.pkt_v_o && hb.pkt_ready_i;
      chk("credits", hb.out_credits_o, MAXC - pending);
      chk("req_yumi", hb.req_yumi_o, hb.req_v_i);
      if (loading) begin
        chk("load_pkt_v", hb.pkt_v_o, hb.load_v_i && pending < MAXC);
        chk("load_yumi", hb.load_yumi_o, hb.load_v_i && pending < MAXC && hb.pkt_ready_i);
        if (hb.pkt_v_o)
          chk("load_pkt_o", hb.pkt_o, mk(hb.load_addr_i, hb.load_data_i, hb.load_x_i, hb.load_y_i));
      end else begin
        chk("idle_yumi", hb.load_yumi_o, 1'b0);
      end
      if (prev_stall) begin
        chk("stall_v", hb.pkt_v_o, 1'b1);
        chk("stall_pkt", hb.pkt_o, prev_pkt);
      end
      if (accept) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pkt act=%0h exp=none", hb.pkt_o);
        end else begin
          e = exp_q.pop_front();
          chk("pkt", hb.pkt_o, e.pkt);
          if (e.unf && !seen_unf) begin
            seen_unf = 1;
            chk("drain_before_unfreeze", pending, 0);
          end
        end
      end
      prev_stall = hb.pkt_v_o && !hb.pkt_ready_i;
      prev_pkt = hb.pkt_o;
      ret = (pending > 0) && (ret_always || $urandom_range(0, 2) == 0);
      hb.credit_return_i = ret;
      pending = pending + int'(accept) - int'(ret);
    end
  end

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_word(input logic [27:0] a, input logic [31:0] d, input logic [1:0] x,
                           input logic [2:0] y, input bit last, input bit fast);
    int w;
    hb.load_v_i = 1'b1;
    hb.load_addr_i = a;
    hb.load_data_i = d;
    hb.load_x_i = x;
    hb.load_y_i = y;
    hb.load_last_i = last;
    w = 0;
    @(negedge clk);
    while (!hb.load_yumi_o && w < 300) begin
      w++;
      @(negedge clk);
    end
    if (fast) chk("load_zero_wait", w, 0);
    chk("load_accept", hb.load_yumi_o, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic run_program(input int n, input bit fast, input bit stall);
    logic [27:0] a;
    logic [31:0] d;
    logic [1:0]  x;
    logic [2:0]  y;
    exp_t        t;
    int          g;
    loading = 1;
    for (int i = 0; i < n; i++) begin
      a = 28'($urandom);
      d = $urandom;
      x = 2'($urandom);
      y = 3'($urandom);
      t.pkt = mk(a, d, x, y);
      t.unf = 0;
      exp_q.push_back(t);
      if (i == n-1) begin
        for (int yy = 1; yy < 4; yy++)
          for (int xx = 0; xx < 4; xx++) begin
            t.pkt = mk(FREEZE_CSR_EPA, 32'h0, 2'(xx), 3'(yy));
            t.unf = 1;
            exp_q.push_back(t);
          end
      end
      if (stall && i == 1) begin
        @(negedge clk);
        stall_until = cyc + 6;
        @(posedge clk); #1;
      end
      send_word(a, d, x, y, i == n-1, fast);
      if (!fast) begin
        hb.load_v_i = 1'b0;
        g = $urandom_range(0, 2);
        repeat (g) begin @(posedge clk); #1; end
      end
    end
    hb.load_v_i = 1'b0;
    hb.load_last_i = 1'b0;
    loading = 0;
  endtask

  task automatic run_tail(input logic [27:0] special);
    int w;
    logic [27:0] a;
    w = 0;
    while (exp_q.size() != 0 && w < 2000) begin
      @(posedge clk);
      w++;
    end
    chk("sb_drained", exp_q.size(), 0);
    #1;
    repeat (3) begin
      a = 28'($urandom);
      while (a == FINISH_EPA || a == FAIL_EPA) a = 28'($urandom);
      hb.req_v_i = 1'b1;
      hb.req_addr_i = a;
      hb.req_data_i = $urandom;
      @(negedge clk);
      chk("noise_done", hb.done_o, 1'b0);
      @(posedge clk); #1;
    end
    hb.req_addr_i = special;
    @(posedge clk); #1;
    hb.req_v_i = 1'b0;
    @(negedge clk);
    chk("run_done", hb.done_o, 1'b1);
    chk("run_fail", hb.fail_o, special == FAIL_EPA);
    @(posedge clk); #1;
    hb.load_v_i = 1'b1;
    hb.load_addr_i = 28'($urandom);
    @(negedge clk);
    chk("done_no_send", hb.pkt_v_o, 1'b0);
    @(posedge clk); #1;
    hb.load_v_i = 1'b0;
    if (special == FINISH_EPA) begin
      hb.req_v_i = 1'b1;
      hb.req_addr_i = FAIL_EPA;
      @(posedge clk); #1;
      hb.req_v_i = 1'b0;
      @(negedge clk);
      chk("done_terminal_fail", hb.fail_o, 1'b0);
      chk("done_terminal_done", hb.done_o, 1'b1);
      @(posedge clk); #1;
    end
  endtask

  // Watchdog so the bench always ends.
  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  // Main stimulus.
  initial begin
    int   n, w;
    exp_t t;
    logic [27:0] a;
    logic [31:0] d;
    hb.load_v_i = 0; hb.load_addr_i = 0; hb.load_data_i = 0; hb.load_x_i = 0;
    hb.load_y_i = 0; hb.load_last_i = 0; hb.req_v_i = 0; hb.req_addr_i = 0; hb.req_data_i = 0;
    h2.load_v_i = 0; h2.load_addr_i = 0; h2.load_data_i = 0; h2.load_x_i = 0;
    h2.load_y_i = 0; h2.load_last_i = 0; h2.req_v_i = 0; h2.req_addr_i = 0; h2.req_data_i = 0;
    h2.pkt_ready_i = 0; h2.credit_return_i = 0;

    // Reset state.
    repeat (16) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pkt_v", hb.pkt_v_o, 1'b0);
    chk("rst_done", hb.done_o, 1'b0);
    chk("rst_fail", hb.fail_o, 1'b0);
    chk("rst_credits", hb.out_credits_o, MAXC);
    chk("rst_yumi", hb.load_yumi_o, 1'b0);

    // Finish write while loading is consumed but ignored.
    @(posedge clk); #1;
    hb.req_v_i = 1'b1;
    hb.req_addr_i = FINISH_EPA;
    @(negedge clk);
    chk("load_finish_yumi", hb.req_yumi_o, 1'b1);
    @(posedge clk); #1;
    hb.req_v_i = 1'b0;
    @(negedge clk);
    chk("load_finish_ignored", hb.done_o, 1'b0);
    @(posedge clk); #1;

    // Run 1: three back-to-back words, ready always high, instant returns, finish.
    run_program(3, 1, 0);
    run_tail(FINISH_EPA);

    // Run 2: random words, random ready and returns, five-cycle stall, fail.
    do_reset(2);
    @(negedge clk);
    chk("rst2_done", hb.done_o, 1'b0);
    chk("rst2_fail", hb.fail_o, 1'b0);
    @(posedge clk); #1;
    ret_always = 0;
    ready_always = 0;
    n = $urandom_range(4, 8);
    run_program(n, 0, 1);
    run_tail(FAIL_EPA);

    // Run 3: reset while the unfreeze sweep sits at x=2, y=1.
    do_reset(2);
    ready_always = 1;
    run_program(2, 0, 0);
    w = 0;
    while (!(hb.pkt_v_o && hb.pkt_o[69:42] == FREEZE_CSR_EPA && hb.pkt_o[9:8] == 2'd2
             && hb.pkt_o[7:5] == 3'd1) && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    chk("found_x2_y1", hb.pkt_v_o, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("abort_pkt_v", hb.pkt_v_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_credits", hb.out_credits_o, MAXC);
    chk("abort_done", hb.done_o, 1'b0);
    chk("abort_pkt_v_after", hb.pkt_v_o, 1'b0);
    @(posedge clk); #1;
    loading = 1;
    a = 28'($urandom);
    d = $urandom;
    t.pkt = mk(a, d, 2'd3, 3'd2);
    t.unf = 0;
    exp_q.push_back(t);
    send_word(a, d, 2'd3, 3'd2, 1'b0, 1'b0);
    hb.load_v_i = 1'b0;
    loading = 0;
    repeat (3) @(posedge clk);
    chk("abort_reload", exp_q.size(), 0);

    // Two-credit instance: two sends with no returns, then one more per return.
    #1;
    h2.load_v_i = 1'b1;
    h2.load_addr_i = 28'h0000040;
    h2.load_data_i = 32'h12345678;
    h2.pkt_ready_i = 1'b1;
    rst2 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst2 = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (h2.pkt_v_o && h2.pkt_ready_i) n++;
    end
    chk("c2_two_sends", n, 2);
    chk("c2_stall_at_zero", h2.pkt_v_o, 1'b0);
    chk("c2_credits_zero", h2.out_credits_o, 0);
    @(posedge clk); #1;
    h2.credit_return_i = 1'b1;
    @(posedge clk); #1;
    h2.credit_return_i = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (h2.pkt_v_o && h2.pkt_ready_i) n++;
    end
    chk("c2_one_more", n, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
